// File: rtl/lsb_evt_if.sv
// lsb_evt_if: register bus between a processor and the lsb_evt event-capture
// block. The master drives the address/write side and the slave returns read
// data and the interrupt request.
interface lsb_evt_if;
   logic        addr;      // 0 = event register, 1 = irq-enable register
   logic        wr;        // one-cycle write strobe
   logic [31:0] data_in;   // write data
   logic [31:0] data_out;  // read data, combinational on addr
   logic        irq;       // registered level interrupt

   modport master (
      output addr,
      output wr,
      output data_in,
      input  data_out,
      input  irq
   );

   modport slave (
      input  addr,
      input  wr,
      input  data_in,
      output data_out,
      output irq
   );
endinterface

// File: rtl/lsb_evt.sv
// lsb_evt: event capture for the debounced button/switch levels.
// Latches rising/falling edges (and, with LSB_EVT_LONG_EN defined, long-press
// events) into sticky write-1-to-clear registers and raises a level interrupt
// for any enabled pending event.
// Optional feature macro: LSB_EVT_LONG_EN (per-input hold counters/long-press).
module lsb_evt #(
   parameter int unsigned NUM_IN     = 8,
   parameter int unsigned LONG_TICKS = 25000000,
   parameter int unsigned CNT_W      = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_IN-1:0] in,
   lsb_evt_if.slave          bus
);

   // Bits of each 8-bit field that correspond to a monitored input.
   localparam logic [7:0] IN_MASK = 8'((9'd1 << NUM_IN) - 9'd1);

   typedef enum logic {
      ST_IDLE,
      ST_ARMED
   } state_t;

   state_t      state;
   state_t      state_next;
   logic        armed;

   logic [7:0]  in_w;
   logic [7:0]  prev;
   logic [7:0]  rise;
   logic [7:0]  fall;
   logic [7:0]  long_q;
   logic [23:0] mask;
   logic        irq_q;

   logic        ev_wr;
   logic        en_wr;
   logic [7:0]  clr_rise;
   logic [7:0]  clr_fall;
   logic [7:0]  clr_long;
   logic [7:0]  rise_set;
   logic [7:0]  fall_set;
   logic [7:0]  long_set;

   logic        unused_bits;

   assign in_w        = 8'(in);
   assign unused_bits = ^bus.data_in[31:24];

   // Arming state register: the first edge after reset only samples prev.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Arming next-state: IDLE always moves to ARMED and stays there.
   always_comb begin
      state_next = state;
      armed      = 1'b0;
      case (state)
         ST_IDLE:  state_next = ST_ARMED;
         ST_ARMED: armed      = 1'b1;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Write decode and edge detection for the sticky event bits.
   always_comb begin
      ev_wr    = bus.wr & ~bus.addr;
      en_wr    = bus.wr &  bus.addr;
      clr_rise = '0;
      clr_fall = '0;
      clr_long = '0;
      if (ev_wr) begin
         clr_rise = bus.data_in[7:0];
         clr_fall = bus.data_in[15:8];
         clr_long = bus.data_in[23:16];
      end
      rise_set = '0;
      fall_set = '0;
      if (armed) begin
         rise_set = in_w & ~prev & IN_MASK;
         fall_set = ~in_w & prev & IN_MASK;
      end
   end

`ifdef LSB_EVT_LONG_EN
   localparam logic [7:0]       LONG_MASK = IN_MASK;
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_NEAR  = CNT_W'(LONG_TICKS - 2);

   logic [CNT_W-1:0] cnt [NUM_IN];

   // Per-input hold counters; saturate so a held input fires only once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_IN; i++) cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!in[i])
               cnt[i] <= '0;
            else if (armed && prev[i] && (cnt[i] != CNT_SAT))
               cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   // Long-press fires on the single increment that reaches saturation.
   always_comb begin
      long_set = '0;
      for (int unsigned i = 0; i < NUM_IN; i++)
         long_set[i] = armed & in[i] & prev[i] & (cnt[i] == CNT_NEAR);
   end
`else
   localparam logic [7:0]  LONG_MASK  = '0;
   localparam int unsigned unused_cfg = LONG_TICKS + CNT_W;

   assign long_set = '0;
`endif

   // Previous-level register, reloaded every cycle independent of writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev <= '0;
      else     prev <= in_w & IN_MASK;
   end

   // Sticky event registers: a set in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise   <= '0;
         fall   <= '0;
         long_q <= '0;
      end else begin
         rise   <= ((rise   & ~clr_rise) | rise_set) & IN_MASK;
         fall   <= ((fall   & ~clr_fall) | fall_set) & IN_MASK;
         long_q <= ((long_q & ~clr_long) | long_set) & LONG_MASK;
      end
   end

   // Interrupt-enable register; bits for absent inputs/features stay 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mask <= '0;
      else if (en_wr)
         mask <= {bus.data_in[23:16] & LONG_MASK,
                  bus.data_in[15:8]  & IN_MASK,
                  bus.data_in[7:0]   & IN_MASK};
   end

   // Registered interrupt from the currently pending enabled events.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) irq_q <= 1'b0;
      else     irq_q <= |({long_q, fall, rise} & mask);
   end

   assign bus.irq      = irq_q;
   assign bus.data_out = bus.addr ? {8'h00, mask} : {8'h00, long_q, fall, rise};

endmodule

// File: tb/tb_lsb_evt.sv
// tb_lsb_evt: directed vector table for edge capture, clearing and irq
// timing, followed by hand-written long-press and mid-operation reset
// sequences. Long-press expectations follow LSB_EVT_LONG_EN.
module tb_lsb_evt;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_lvl = 8'h01;

   lsb_evt_if bus ();

   lsb_evt #(
      .NUM_IN     (8),
      .LONG_TICKS (10),
      .CNT_W      (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .in  (in_lvl),
      .bus (bus)
   );

   always #5 clk = ~clk;

`ifdef LSB_EVT_LONG_EN
   localparam bit LONG_ON = 1'b1;
`else
   localparam bit LONG_ON = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  lvl;
      logic        wr;
      logic        addr;
      logic [31:0] din;
      logic [31:0] evt;
      logic        irq;
   } vec_t;

   vec_t vq[$];

   function automatic void add(input logic [7:0] lvl, input logic wr, input logic addr,
                               input logic [31:0] din, input logic [31:0] evt,
                               input logic irq);
      vec_t v;
      v.lvl = lvl; v.wr = wr; v.addr = addr; v.din = din; v.evt = evt; v.irq = irq;
      vq.push_back(v);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic a, output logic [31:0] v);
      bus.addr = a;
      #1;
      v = bus.data_out;
   endtask

   logic [31:0] rv;
   logic [31:0] exp_v;

   initial begin
      bus.addr    = 1'b0;
      bus.wr      = 1'b0;
      bus.data_in = '0;

      // Table: inputs applied before each edge, outputs checked just after.
      add(8'h01, 0, 0, 32'h0,        32'h0,   0); // arming edge, in[0] high
      add(8'h01, 0, 0, 32'h0,        32'h0,   0);
      add(8'h01, 0, 0, 32'h0,        32'h0,   0); // no spurious rise[0]
      add(8'h00, 0, 0, 32'h0,        32'h100, 0); // fall[0]
      add(8'h00, 1, 0, 32'h100,      32'h0,   0); // clear fall[0]
      add(8'h00, 1, 1, 32'h000001,   32'h0,   0); // enable rise[0]
      add(8'h05, 0, 0, 32'h0,        32'h5,   0); // rise[0], rise[2]
      add(8'h05, 0, 0, 32'h0,        32'h5,   1); // irq one edge later
      add(8'h00, 1, 0, 32'h5,        32'h500, 1); // clear rises, falls set
      add(8'h00, 0, 0, 32'h0,        32'h500, 0); // irq drops
      add(8'h00, 1, 1, 32'h00FF00,   32'h500, 0); // enable all falls
      add(8'h00, 0, 0, 32'h0,        32'h500, 1);
      add(8'h00, 1, 0, 32'h400,      32'h100, 1); // partial clear fall[2]
      add(8'h00, 1, 0, 32'h100,      32'h0,   1);
      add(8'h00, 0, 0, 32'h0,        32'h0,   0);
      add(8'h08, 0, 0, 32'h0,        32'h8,   0); // rise[3], not enabled
      add(8'h00, 1, 0, 32'h8,        32'h800, 0); // clear rise[3], fall[3]
      add(8'h08, 1, 0, 32'h808,      32'h8,   1); // set beats clear on rise[3]
      add(8'h08, 1, 1, 32'hFFFFFF,   32'h8,   0); // enable all
      add(8'h00, 0, 0, 32'h0,        32'h808, 1);
      add(8'h08, 0, 0, 32'h0,        32'h808, 1); // sticky, repeated rise
      add(8'h00, 1, 0, 32'hFFFFFF,   32'h800, 1); // set beats clear on fall[3]
      add(8'h00, 1, 0, 32'hFFFFFF,   32'h0,   1);
      add(8'h00, 0, 0, 32'h0,        32'h0,   0);

      // Reset state with in[0] held high.
      #2;
      rd(1'b0, rv); check("reset_evt", rv, 32'h0);
      check("reset_irq", {31'b0, bus.irq}, 32'h0);
      rd(1'b1, rv); check("reset_en", rv, 32'h0);
      bus.addr = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vq[n]) begin
         in_lvl      = vq[n].lvl;
         bus.wr      = vq[n].wr;
         bus.addr    = vq[n].addr;
         bus.data_in = vq[n].din;
         tick();
         bus.wr   = 1'b0;
         bus.addr = 1'b0;
         #1;
         check($sformatf("vec%0d_evt", n), bus.data_out, vq[n].evt);
         check($sformatf("vec%0d_irq", n), {31'b0, bus.irq}, {31'b0, vq[n].irq});
      end

      rd(1'b1, rv);
      check("en_readback", rv, LONG_ON ? 32'h00FF_FFFF : 32'h0000_FFFF);
      bus.addr = 1'b0;

      // Long press on in[1]: rise at edge 0, long at edge LONG_TICKS-1.
      in_lvl = 8'h02;
      tick();
      rd(1'b0, rv); check("hold_rise", rv, 32'h2);
      for (int t = 1; t <= 19; t++) begin
         tick();
         rd(1'b0, rv);
         exp_v = (LONG_ON && t >= 9) ? 32'h0002_0002 : 32'h0000_0002;
         check($sformatf("hold_t%0d", t), rv, exp_v);
      end

      // Cleared while still held: the saturated counter must not refire.
      bus.wr = 1'b1; bus.data_in = 32'h0002_0000;
      tick();
      bus.wr = 1'b0;
      for (int t = 0; t < 3; t++) begin
         tick();
         rd(1'b0, rv); check($sformatf("long_once%0d", t), rv, 32'h2);
      end

      in_lvl = 8'h00;
      tick();
      rd(1'b0, rv); check("long_release", rv, 32'h202);
      bus.wr = 1'b1; bus.data_in = 32'hFFFFFF;
      tick();
      bus.wr = 1'b0;
      rd(1'b0, rv); check("long_clear", rv, 32'h0);

      // Re-press restarts the count.
      in_lvl = 8'h02;
      tick();
      rd(1'b0, rv); check("repress_rise", rv, 32'h2);
      for (int t = 1; t <= 9; t++) tick();
      rd(1'b0, rv); check("repress_long", rv, LONG_ON ? 32'h0002_0002 : 32'h0000_0002);
      check("pre_rst_irq", {31'b0, bus.irq}, 32'h1);

      // Asynchronous reset mid-hold.
      #2 rst = 1'b1;
      #1;
      check("rst_irq", {31'b0, bus.irq}, 32'h0);
      rd(1'b0, rv); check("rst_evt", rv, 32'h0);
      rd(1'b1, rv); check("rst_en", rv, 32'h0);
      bus.addr = 1'b0;
      rst = 1'b0;
      for (int t = 0; t < 3; t++) tick();
      rd(1'b0, rv); check("rearm_no_rise", rv, 32'h0);
      check("rearm_irq", {31'b0, bus.irq}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsb_evt.md
Name: lsb_evt

Overview:
- Event-capture stage directly downstream of the LED/switch/button block.
- Consumes its debounced btn/swi levels and latches press (rising), release (falling) and, optionally, long-press events into sticky registers.
- Software reads the registers and clears them with write-1-to-clear.
- Raises a level interrupt for any enabled pending event, so the processor no longer has to poll raw levels.

Parameters:
- NUM_IN, 8, number of inputs monitored (1..8); in[3:0] = btn, in[7:4] = swi; unused register bits read 0.
- LONG_TICKS, 25000000, clock cycles an input must stay high to raise a long-press event (>= 2).
- CNT_W, 25, hold-counter width; must satisfy 2^CNT_W > LONG_TICKS.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- in  input  NUM_IN  debounced levels (btn/swi outputs of the LSB block), synchronous to clk
- addr  input  1  0 = event register, 1 = irq-enable register
- wr  input  1  write strobe, one cycle per write
- data_in  input  32  write data
- data_out  output  32  read data for selected register, combinational on addr
- irq  output  1  registered interrupt request, level

Behaviour:
- Reset (async on rst high): rise, fall, long, mask, prev, irq, armed, hold counters all 0; data_out reflects zeros.
- Event register read (addr=0): {8'b0, long[7:0], fall[7:0], rise[7:0]}.
- Enable register read (addr=1): {8'b0, en_long[7:0], en_fall[7:0], en_rise[7:0]}.
- Arming:
  - First posedge after rst deasserts loads prev <= in, sets armed=1, generates no events.
  - Inputs already high at reset therefore produce no spurious rise.
- Edge detect (armed=1), per bit i, every posedge:
  - in[i]=1 & prev[i]=0 sets rise[i].
  - in[i]=0 & prev[i]=1 sets fall[i].
  - prev <= in.
- Latency:
  - Level change sampled at posedge k -> event bit visible on data_out after posedge k.
  - irq asserts after posedge k+1.
- Sticky: event bits stay set until cleared; repeated edges while set have no further effect (no count).
- Clear: wr with addr=0 clears each event bit whose data_in bit is 1 (rise = [7:0], fall = [15:8], long = [23:16]); 0 bits are untouched.
- Set/clear collision: set wins in the same cycle; the event is never lost.
- Enable write: wr with addr=1 loads mask <= data_in[23:0]; bits >= NUM_IN in each field are forced to 0.
- irq: irq <= |({long,fall,rise} & mask), registered every cycle; drops one cycle after the last enabled pending bit clears or its mask bit clears.
- Reset mid-operation: all state returns to reset values immediately; armed cleared; pending events discarded.
- wr with any addr never affects edge detection or prev.

Optional Feature:
- Macro: LSB_EVT_LONG_EN.
- Defined:
  - Per-input hold counter cnt[i] (CNT_W bits) increments while armed & in[i]=1 & prev[i]=1, and clears when in[i]=0.
  - Saturates at LONG_TICKS-1.
  - Transition of cnt[i] to LONG_TICKS-1 sets long[i] exactly once per press.
  - A new press restarts the count; wrap-around is impossible.
- Undefined: no counters synthesized; long bits and en_long bits read 0; writes to them are ignored.

Test Plan:
- Reset with in=8'h01 held, release rst, wait 3 cycles -> data_out=0 at addr 0; no rise[0].
- in 0->8'h05 at posedge k -> event register reads 32'h0000_0005 after k; with mask=32'h0000_0001, irq=1 after k+1.
- in 8'h05->0, write addr0 data_in=32'h0000_0005 -> read 32'h0000_0500 (fall[0], fall[2]); irq=0 two cycles later.
- Rise on in[3] in the same cycle as a write-1-to-clear of rise[3] -> rise[3] remains 1.
- LSB_EVT_LONG_EN, LONG_TICKS=10: hold in[1] for 20 cycles -> long[1] set once, ~10 cycles after the rise; read 32'h0002_0002. Release then re-press after clear -> long[1] set again.
- Assert rst mid-hold with mask=32'hFFFFFF -> irq drops asynchronously and all registers read 0.
